pwm_duty_ramp: RTL and testbench

- Upstream duty-cycle source for the pwm block. Its duty output connects directly to the pwm duty input.
- Accepts a target duty through a valid/ready handshake.
- Slews its registered duty output toward the target in programmable steps, at a programmable clk-cycle interval. This gives the PWM output soft-start and soft-stop.
- Signals completion with a one-cycle done pulse.

---
 rtl/pwm_duty_ramp_if.sv | 25 ++
 rtl/pwm_duty_ramp.sv | 135 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ramp_if.sv
// Target-request channel feeding pwm_duty_ramp: target duty, ramp step and
// update interval, qualified by a valid/ready handshake.
interface pwm_duty_ramp_if #(
  parameter int WIDTH      = 8,
  parameter int STEP_WIDTH = 4,
  parameter int DIV_WIDTH  = 16
);
  logic [WIDTH:0]          target_duty;
  logic                    target_valid;
  logic                    target_ready;
  logic [STEP_WIDTH-1:0]   step;
  logic [DIV_WIDTH-1:0]    update_interval;

  // Requester side
  modport master (
    output target_duty, target_valid, step, update_interval,
    input  target_ready
  );

  // Ramp generator side
  modport slave (
    input  target_duty, target_valid, step, update_interval,
    output target_ready
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp generator: accepts a target duty and slews the registered
// duty output toward it by a fixed step every N clocks, giving the PWM
// output soft-start / soft-stop. A one-cycle done pulse marks arrival.
module pwm_duty_ramp #(
  parameter int WIDTH      = 8,
  parameter int STEP_WIDTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_duty_ramp_if.slave       tgt,
  input  logic                 hold,
  output logic [WIDTH:0]       duty,
  output logic                 ramping,
  output logic                 done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  // 2^WIDTH: the "always on" duty value and the clamp ceiling for targets
  localparam logic [WIDTH:0] FULL_DUTY = {1'b1, {WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [WIDTH:0]        duty_q, duty_d;
  logic [WIDTH:0]        tgt_q, tgt_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [DIV_WIDTH-1:0]  ivl_q, ivl_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;

  // Request decode: clamp the target and map zero step/interval to one
  logic [WIDTH:0]        req_tgt;
  logic [STEP_WIDTH-1:0] req_step;
  logic [DIV_WIDTH-1:0]  req_ivl;

  // One extra bit of headroom so duty+step and target+step never wrap
  logic [WIDTH+1:0]      duty_w, tgt_w, step_w, sum_w, lim_w, next_w;

  // Decode the incoming request fields
  always_comb begin
    req_tgt  = (tgt.target_duty > FULL_DUTY) ? FULL_DUTY : tgt.target_duty;
    req_step = (tgt.step == '0) ? STEP_WIDTH'(1) : tgt.step;
    req_ivl  = (tgt.update_interval == '0) ? DIV_WIDTH'(1) : tgt.update_interval;
  end

  // Next duty value after one update, saturating at the target in either direction
  always_comb begin
    duty_w = {1'b0, duty_q};
    tgt_w  = {1'b0, tgt_q};
    step_w = '0;
    step_w[STEP_WIDTH-1:0] = step_q;
    sum_w  = duty_w + step_w;
    lim_w  = tgt_w + step_w;
    if (duty_w < tgt_w) begin
      next_w = (sum_w > tgt_w) ? tgt_w : sum_w;
    end else if (duty_w >= lim_w) begin
      next_w = duty_w - step_w;
    end else begin
      next_w = tgt_w;
    end
  end

  // Next-state logic: accept in IDLE, count and update in RAMP
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    ivl_d   = ivl_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tgt.target_valid) begin
          tgt_d  = req_tgt;
          step_d = req_step;
          ivl_d  = req_ivl;
          cnt_d  = '0;
          if (req_tgt == duty_q) begin
            // Already there: acknowledge with done but never enter RAMP
            done_d = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (!hold) begin
          if (cnt_q == ivl_q - DIV_WIDTH'(1)) begin
            cnt_d  = '0;
            duty_d = next_w[WIDTH:0];
            if (next_w == tgt_w) begin
              // Final duty and done become visible in the same cycle
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      ivl_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      ivl_q   <= ivl_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign tgt.target_ready = (state_q == ST_IDLE);
  assign ramping          = (state_q == ST_RAMP);
  assign duty             = duty_q;
  assign done             = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed scenarios followed by random traffic,
// each cycle compared against a queue-based ramp model.
module tb_pwm_duty_ramp;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam int DW = 16;
  localparam int FULL = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hold = 1'b0;
  logic [W:0]   duty;
  logic         ramping;
  logic         done;

  pwm_duty_ramp_if #(.WIDTH(W), .STEP_WIDTH(SW), .DIV_WIDTH(DW)) tif ();

  pwm_duty_ramp #(.WIDTH(W), .STEP_WIDTH(SW), .DIV_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tgt     (tif.slave),
    .hold    (hold),
    .duty    (duty),
    .ramping (ramping),
    .done    (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: on acceptance the full list of duty values is built;
  // one value is released every N non-held edges.
  int m_duty   = 0;
  int m_n      = 1;
  int m_active = 0;
  bit m_busy   = 0;
  bit m_done   = 0;
  int m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input int t, input int s, input int n, input bit h);
    int ct, es, en, x;
    bit dn;
    dn = 0;
    if (!r) begin
      m_duty = 0; m_busy = 0; m_q.delete();
    end else if (!m_busy) begin
      if (v) begin
        ct = (t > FULL) ? FULL : t;
        es = (s == 0) ? 1 : s;
        en = (n == 0) ? 1 : n;
        if (ct == m_duty) begin
          dn = 1;
        end else begin
          x = m_duty;
          while (x != ct) begin
            if (x < ct) x = (x + es > ct) ? ct : x + es;
            else        x = (x - es < ct) ? ct : x - es;
            m_q.push_back(x);
          end
          m_n = en; m_active = 0; m_busy = 1;
        end
      end
    end else if (!h) begin
      m_active++;
      if (m_active % m_n == 0) begin
        m_duty = m_q.pop_front();
        if (m_q.size() == 0) begin
          m_busy = 0; dn = 1;
        end
      end
    end
    m_done = dn;
  endtask

  task automatic cyc(input bit r, input bit v, input int t, input int s, input int n, input bit h);
    int tv, sv, nv;
    tv = t & 511; sv = s & 15; nv = n & 65535;
    @(negedge clk);
    rst_n = r; hold = h;
    tif.target_valid    = v;
    tif.target_duty     = tv[W:0];
    tif.step            = sv[SW-1:0];
    tif.update_interval = nv[DW-1:0];
    @(posedge clk);
    model_edge(r, v, tv, sv, nv, h);
    #1;
    check("duty", 32'(duty), 32'(m_duty));
    check("done", 32'(done), 32'(m_done));
    check("ready", 32'(tif.target_ready), 32'(!m_busy));
    check("ramping", 32'(ramping), 32'(m_busy));
    $display("t=%0t rst_n=%0d v=%0d tgt=%0d step=%0d n=%0d hold=%0d -> duty=%0d done=%0d ready=%0d ramping=%0d",
             $time, r, v, tv, sv, nv, h, duty, done, tif.target_ready, ramping);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tif.target_valid = 0; tif.target_duty = '0; tif.step = '0; tif.update_interval = '0;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(1);
    // Up ramp 0 -> 128, step 16, every cycle
    cyc(1, 1, 128, 16, 1, 0);
    idle(10);
    // Down ramp 128 -> 50, step 16, every 10 cycles, last step clamped
    cyc(1, 1, 50, 16, 10, 0);
    idle(60);
    // Reach 250, then saturating request with zero step and interval
    cyc(1, 1, 250, 15, 1, 0);
    idle(20);
    cyc(1, 1, 300, 0, 0, 0);
    idle(10);
    // Equal-target requests, including back-to-back
    cyc(1, 1, 64, 15, 1, 0);
    idle(20);
    cyc(1, 1, 64, 3, 1, 0);
    idle(2);
    cyc(1, 1, 64, 3, 1, 0);
    cyc(1, 1, 64, 3, 1, 0);
    idle(2);
    // Request during a ramp must be ignored
    cyc(1, 1, 200, 8, 2, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 1, 1, 0);
    idle(40);
    // Hold mid-interval (interval 4, counter at 2)
    cyc(1, 1, 0, 16, 4, 0);
    idle(2);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 1);
    idle(60);
    // Reset mid-ramp at duty 80
    cyc(1, 1, 200, 16, 1, 0);
    idle(5);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    idle(2);
    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, v, h;
      int t, s, n;
      r = ($urandom_range(0, 299) != 0);
      v = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 7) == 0) ? m_duty : int'($urandom_range(0, 511));
      s = int'($urandom_range(0, 15));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 2));
      h = ($urandom_range(0, 7) == 0);
      cyc(r, v, t, s, n, h);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
